// File: rtl/imm_pkg.sv
// Shared type codes, opcodes and buffer state encoding for the immediate decode stage.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package imm_pkg;

  // Resolved immediate type codes; anything above IMM_J is illegal.
  localparam logic [2:0] IMM_I       = 3'b000;
  localparam logic [2:0] IMM_S       = 3'b001;
  localparam logic [2:0] IMM_B       = 3'b010;
  localparam logic [2:0] IMM_U       = 3'b011;
  localparam logic [2:0] IMM_J       = 3'b100;
  localparam logic [2:0] IMM_ILLEGAL = 3'b111;

  // Major opcodes (instr[6:0]) that carry an immediate.
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  // Occupancy of the two-entry output/skid buffer.
  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_FULL  = 2'd2
  } buf_state_e;

  // Map an opcode to its immediate format; unknown opcodes resolve to IMM_ILLEGAL.
  function automatic logic [2:0] opcode_to_type(input logic [6:0] opc);
    logic [2:0] t;
    case (opc)
      OPC_LOAD, OPC_OPIMM, OPC_JALR: t = IMM_I;
      OPC_STORE:                     t = IMM_S;
      OPC_BRANCH:                    t = IMM_B;
      OPC_LUI, OPC_AUIPC:            t = IMM_U;
      OPC_JAL:                       t = IMM_J;
      default:                       t = IMM_ILLEGAL;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/immediate_decode_stage_if.sv
// Instruction-in / immediate-out handshake bundle for the immediate decode stage.
// Latency: n/a (wiring only).
// Backpressure: valid/ready on both sides; the producer holds in_* until in_ready.
interface immediate_decode_stage_if #(
  parameter int XLEN  = 64,
  parameter int TAG_W = 64
);
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       in_instr;
  logic [2:0]        in_imm_type;
  logic [TAG_W-1:0]  in_tag;

  logic              out_valid;
  logic              out_ready;
  logic [XLEN-1:0]   out_imm;
  logic [2:0]        out_imm_type;
  logic              out_illegal;
  logic [TAG_W-1:0]  out_tag;

  // Producer of instructions and consumer of immediates (fetch side + ID/EX).
  modport master (
    output in_valid, in_instr, in_imm_type, in_tag, out_ready,
    input  in_ready, out_valid, out_imm, out_imm_type, out_illegal, out_tag
  );

  // The decode stage itself.
  modport slave (
    input  in_valid, in_instr, in_imm_type, in_tag, out_ready,
    output in_ready, out_valid, out_imm, out_imm_type, out_illegal, out_tag
  );
endinterface

// File: rtl/imm_extract.sv
// Combinational immediate assembly and sign extension for I/S/B/U/J formats.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller registers the result.
module imm_extract
  import imm_pkg::*;
#(
  parameter int XLEN        = 64,
  parameter int AUTO_DECODE = 1
) (
  input  logic [31:0]     instr,
  input  logic [2:0]      imm_type,
  output logic [XLEN-1:0] imm,
  output logic [2:0]      res_type,
  output logic            illegal
);

  logic [2:0]  sel_type;
  logic [31:0] imm32;

  // The type source is fixed at elaboration: opcode decode or the explicit input.
  generate
    if (AUTO_DECODE != 0) begin : g_auto
      logic unused_imm_type;
      assign sel_type        = opcode_to_type(instr[6:0]);
      assign unused_imm_type = ^imm_type;
    end else begin : g_manual
      logic unused_opcode;
      assign sel_type      = imm_type;
      assign unused_opcode = ^instr[6:0];
    end
  endgenerate

  // Scatter-gather the immediate bits into a 32-bit sign-extended value.
  always_comb begin
    imm32    = '0;
    res_type = sel_type;
    illegal  = 1'b0;
    case (sel_type)
      IMM_I: imm32 = {{20{instr[31]}}, instr[31:20]};
      IMM_S: imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B: imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                      instr[11:8], 1'b0};
      IMM_U: imm32 = {instr[31:12], 12'b0};
      IMM_J: imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                      instr[30:21], 1'b0};
      default: begin
        // Unsupported types still flow down the pipe, flagged, with a zero immediate.
        imm32   = '0;
        illegal = 1'b1;
      end
    endcase
  end

  // Widen to XLEN; for XLEN=32 the upper fill is fully overwritten.
  always_comb begin
    imm       = {XLEN{imm32[31]}};
    imm[31:0] = imm32;
  end

endmodule

// File: rtl/immediate_decode_stage.sv
// Decode-stage immediate generator: one instruction in, one sign-extended immediate out.
// Latency: 1 cycle from input transfer to out_valid; throughput 1/cycle when out_ready holds.
// Backpressure: 2-entry output+skid buffer; in_ready drops only when both entries are held.
module immediate_decode_stage
  import imm_pkg::*;
#(
  parameter int XLEN        = 64,
  parameter int TAG_W       = 64,
  parameter int AUTO_DECODE = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic flush,
  immediate_decode_stage_if.slave bus
);

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic [2:0]       imm_type;
    logic             illegal;
    logic [TAG_W-1:0] tag;
  } entry_t;

  buf_state_e       state;
  buf_state_e       state_nxt;
  entry_t           head;       // entry 0: drives out_*
  entry_t           skid;       // entry 1: holds the overflow while head stalls
  entry_t           new_entry;
  logic [XLEN-1:0]  ext_imm;
  logic [2:0]       ext_type;
  logic             ext_illegal;
  logic             push;
  logic             pop;
  logic             head_ld_new;
  logic             head_ld_skid;
  logic             skid_ld_new;

  imm_extract #(
    .XLEN        (XLEN),
    .AUTO_DECODE (AUTO_DECODE)
  ) u_extract (
    .instr    (bus.in_instr),
    .imm_type (bus.in_imm_type),
    .imm      (ext_imm),
    .res_type (ext_type),
    .illegal  (ext_illegal)
  );

  assign new_entry = '{imm: ext_imm, imm_type: ext_type, illegal: ext_illegal,
                       tag: bus.in_tag};

  // in_ready ignores same-cycle pops so it never depends on out_ready combinationally.
  assign bus.in_ready  = (state != BUF_FULL);
  assign bus.out_valid = (state != BUF_EMPTY);
  assign push          = bus.in_valid && bus.in_ready;
  assign pop           = bus.out_valid && bus.out_ready;

  assign bus.out_imm      = head.imm;
  assign bus.out_imm_type = head.imm_type;
  assign bus.out_illegal  = head.illegal;
  assign bus.out_tag      = head.tag;

  // Occupancy state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= BUF_EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  // Next occupancy and entry load selects; flush overrides any push or pop.
  always_comb begin
    state_nxt    = state;
    head_ld_new  = 1'b0;
    head_ld_skid = 1'b0;
    skid_ld_new  = 1'b0;
    if (flush) begin
      state_nxt = BUF_EMPTY;
    end else begin
      case (state)
        BUF_EMPTY: begin
          if (push) begin
            state_nxt   = BUF_ONE;
            head_ld_new = 1'b1;
          end
        end
        BUF_ONE: begin
          if (push && pop) begin
            head_ld_new = 1'b1;
          end else if (push) begin
            state_nxt   = BUF_FULL;
            skid_ld_new = 1'b1;
          end else if (pop) begin
            state_nxt = BUF_EMPTY;
          end
        end
        BUF_FULL: begin
          // No push is possible here because in_ready is low.
          if (pop) begin
            state_nxt    = BUF_ONE;
            head_ld_skid = 1'b1;
          end
        end
        default: state_nxt = BUF_EMPTY;
      endcase
    end
  end

  // Head register: loads new data or promotes the skid entry; otherwise holds stable.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head.imm      <= '0;
      head.imm_type <= IMM_ILLEGAL;
      head.illegal  <= 1'b0;
      head.tag      <= '0;
    end else if (head_ld_new) begin
      head <= new_entry;
    end else if (head_ld_skid) begin
      head <= skid;
    end
  end

  // Skid register: captures the input that arrives while the head is stalled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      skid <= '0;
    end else if (skid_ld_new) begin
      skid <= new_entry;
    end
  end

endmodule

// File: tb/tb_immediate_decode_stage.sv
// Scoreboard bench for immediate_decode_stage (XLEN=64 auto-decode and XLEN=32 explicit type).
// Latency: expects 1-cycle transfer-to-output, 1/cycle throughput.
// Backpressure: exercises stall, skid fill, flush and asynchronous reset.
module tb_immediate_decode_stage;

  logic clk = 1'b0;
  logic reset;
  logic flush;

  always #5 clk = ~clk;

  immediate_decode_stage_if #(.XLEN(64), .TAG_W(64)) b64 ();
  immediate_decode_stage_if #(.XLEN(32), .TAG_W(64)) b32 ();

  immediate_decode_stage #(.XLEN(64), .TAG_W(64), .AUTO_DECODE(1)) dut64 (
    .clk (clk), .reset (reset), .flush (flush), .bus (b64)
  );

  immediate_decode_stage #(.XLEN(32), .TAG_W(64), .AUTO_DECODE(0)) dut32 (
    .clk (clk), .reset (reset), .flush (flush), .bus (b32)
  );

  typedef struct {
    logic [63:0] imm;
    logic [2:0]  typ;
    logic        ill;
    logic [63:0] tag;
  } exp_t;

  exp_t        q64[$];
  exp_t        q32[$];
  exp_t        e64;
  exp_t        e32;
  int          n_checks = 0;
  int          n_pass   = 0;
  int          n_out64  = 0;
  int          n_out32  = 0;
  logic [63:0] next_tag = 64'hA000_0000_0000_0001;

  // Reference type decode, written from the opcode table.
  function automatic logic [2:0] ref_type(input logic [31:0] i);
    case (i[6:0])
      7'h03, 7'h13, 7'h67: return 3'd0;
      7'h23:               return 3'd1;
      7'h63:               return 3'd2;
      7'h37, 7'h17:        return 3'd3;
      7'h6F:               return 3'd4;
      default:             return 3'd7;
    endcase
  endfunction

  // Reference 64-bit immediate for a given type.
  function automatic logic [63:0] ref_imm(input logic [31:0] i, input logic [2:0] t);
    case (t)
      3'd0: return {{52{i[31]}}, i[31:20]};
      3'd1: return {{52{i[31]}}, i[31:25], i[11:7]};
      3'd2: return {{51{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      3'd3: return {{32{i[31]}}, i[31:12], 12'b0};
      3'd4: return {{43{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      default: return 64'd0;
    endcase
  endfunction

  function automatic exp_t make_exp(input logic [31:0] i, input logic [63:0] tag, input bit narrow);
    exp_t e;
    e.typ = ref_type(i);
    e.imm = ref_imm(i, e.typ);
    if (narrow) e.imm = {32'd0, e.imm[31:0]};
    e.ill = (e.typ > 3'd4);
    e.tag = tag;
    return e;
  endfunction

  // Single comparison point: count, and report any mismatch.
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // The narrow DUT mirrors the wide one's stimulus, with its type supplied explicitly.
  assign b32.in_valid    = b64.in_valid;
  assign b32.in_instr    = b64.in_instr;
  assign b32.in_tag      = b64.in_tag;
  assign b32.in_imm_type = ref_type(b64.in_instr);
  assign b32.out_ready   = b64.out_ready;

  // Scoreboard: compare each output transfer, then record each input transfer.
  always @(negedge clk) begin
    if (reset || flush) begin
      q64.delete();
      q32.delete();
    end else begin
      if (b64.out_valid && b64.out_ready) begin
        n_out64++;
        check("sb64_avail", 64'(q64.size() != 0), 64'd1);
        if (q64.size() != 0) begin
          e64 = q64.pop_front();
          check("sb64_imm",  b64.out_imm, e64.imm);
          check("sb64_type", 64'(b64.out_imm_type), 64'(e64.typ));
          check("sb64_ill",  64'(b64.out_illegal), 64'(e64.ill));
          check("sb64_tag",  b64.out_tag, e64.tag);
        end
      end
      if (b32.out_valid && b32.out_ready) begin
        n_out32++;
        check("sb32_avail", 64'(q32.size() != 0), 64'd1);
        if (q32.size() != 0) begin
          e32 = q32.pop_front();
          check("sb32_imm",  64'(b32.out_imm), e32.imm);
          check("sb32_type", 64'(b32.out_imm_type), 64'(e32.typ));
          check("sb32_ill",  64'(b32.out_illegal), 64'(e32.ill));
          check("sb32_tag",  b32.out_tag, e32.tag);
        end
      end
      if (b64.in_valid && b64.in_ready) q64.push_back(make_exp(b64.in_instr, b64.in_tag, 1'b0));
      if (b32.in_valid && b32.in_ready) q32.push_back(make_exp(b32.in_instr, b32.in_tag, 1'b1));
    end
  end

  // Present one instruction and hold it until accepted (bounded); called at posedge+1.
  task automatic send(input logic [31:0] instr);
    bit done;
    done           = 1'b0;
    b64.in_valid   = 1'b1;
    b64.in_instr   = instr;
    b64.in_tag     = next_tag;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge clk);
      done = b64.in_ready;
      @(posedge clk);
      #1;
    end
    check("send_accept", 64'(done), 64'd1);
    next_tag     = next_tag + 64'd1;
    b64.in_valid = 1'b0;
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_valid"}, 64'(b64.out_valid), 64'd0);
    check({pfx, "_ready"}, 64'(b64.in_ready), 64'd1);
    check({pfx, "_imm"},   b64.out_imm, 64'd0);
    check({pfx, "_type"},  64'(b64.out_imm_type), 64'd7);
    check({pfx, "_ill"},   64'(b64.out_illegal), 64'd0);
    check({pfx, "_tag"},   b64.out_tag, 64'd0);
    check({pfx, "_type32"}, 64'(b32.out_imm_type), 64'd7);
    check({pfx, "_valid32"}, 64'(b32.out_valid), 64'd0);
  endtask

  int base64;
  int base32;
  logic [63:0] t0;

  initial begin
    reset        = 1'b0;
    flush        = 1'b0;
    b64.in_valid = 1'b0;
    b64.in_instr = 32'd0;
    b64.in_tag   = 64'd0;
    b64.in_imm_type = 3'd0;
    b64.out_ready   = 1'b1;
    #2 reset = 1'b1;
    #2 check_reset_outputs("rst");
    @(posedge clk); #1 reset = 1'b0;

    // addi x1,x0,-1
    t0 = next_tag;
    send(32'hFFF00093);
    @(negedge clk);
    check("addi_valid", 64'(b64.out_valid), 64'd1);
    check("addi_imm",   b64.out_imm, 64'hFFFF_FFFF_FFFF_FFFF);
    check("addi_type",  64'(b64.out_imm_type), 64'd0);
    check("addi_tag",   b64.out_tag, t0);
    check("addi_imm32", 64'(b32.out_imm), 64'h0000_0000_FFFF_FFFF);

    // sd then beq back-to-back: latency 1, one per cycle
    @(posedge clk); #1;
    b64.in_valid = 1'b1; b64.in_instr = 32'h00B53423; b64.in_tag = 64'h11;
    @(posedge clk); #1;
    b64.in_instr = 32'hFE000EE3; b64.in_tag = 64'h22;
    @(negedge clk);
    check("sd_imm",   b64.out_imm, 64'h8);
    check("sd_type",  64'(b64.out_imm_type), 64'd1);
    check("sd_ready", 64'(b64.in_ready), 64'd1);
    @(posedge clk); #1 b64.in_valid = 1'b0;
    @(negedge clk);
    check("beq_valid", 64'(b64.out_valid), 64'd1);
    check("beq_imm",   b64.out_imm, 64'hFFFF_FFFF_FFFF_FFFC);
    check("beq_type",  64'(b64.out_imm_type), 64'd2);
    check("beq_tag",   b64.out_tag, 64'h22);

    // lui 0x80000 at both widths
    @(posedge clk); #1;
    send(32'h800000B7);
    @(negedge clk);
    check("lui_imm64",  b64.out_imm, 64'hFFFF_FFFF_8000_0000);
    check("lui_imm32",  64'(b32.out_imm), 64'h0000_0000_8000_0000);
    check("lui_type32", 64'(b32.out_imm_type), 64'd3);

    // Back-pressure: out_ready low for three edges while four instructions stream in
    @(posedge clk); #1;
    base64 = n_out64; base32 = n_out32;
    b64.out_ready = 1'b0;
    fork
      begin
        repeat (3) @(posedge clk);
        #1 b64.out_ready = 1'b1;
      end
      begin
        send(32'h00A00513);
        send(32'hFFDFF0EF);
        b64.in_valid = 1'b1; b64.in_instr = 32'h12345017; b64.in_tag = next_tag;
        @(negedge clk);
        check("bp_full_ready", 64'(b64.in_ready), 64'd0);
        check("bp_hold_valid", 64'(b64.out_valid), 64'd1);
        check("bp_hold_imm",   b64.out_imm, 64'd10);
        @(posedge clk); #1;
        send(32'h12345017);
        send(32'hFE112E23);
      end
    join
    repeat (4) @(posedge clk);
    #1;
    check("bp_count64", 64'(n_out64 - base64), 64'd4);
    check("bp_count32", 64'(n_out32 - base32), 64'd4);
    check("bp_drain64", 64'(q64.size()), 64'd0);
    check("bp_drain32", 64'(q32.size()), 64'd0);

    // Flush with two buffered and a third presented
    base64 = n_out64;
    b64.out_ready = 1'b0;
    send(32'h00100093);
    send(32'h00200113);
    b64.in_valid = 1'b1; b64.in_instr = 32'h00300193; b64.in_tag = next_tag;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; b64.in_valid = 1'b0;
    @(negedge clk);
    check("flush_valid", 64'(b64.out_valid), 64'd0);
    check("flush_ready", 64'(b64.in_ready), 64'd1);
    // Flush with one buffered while in_ready is high
    @(posedge clk); #1;
    send(32'h00400213);
    b64.in_valid = 1'b1; b64.in_instr = 32'h00500293; b64.in_tag = next_tag;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; b64.in_valid = 1'b0;
    b64.out_ready = 1'b1;
    @(negedge clk);
    check("flush1_valid", 64'(b64.out_valid), 64'd0);
    repeat (4) @(posedge clk);
    #1;
    check("flush_no_leak", 64'(n_out64 - base64), 64'd0);

    // Unsupported opcode
    send(32'h0000007F);
    @(negedge clk);
    check("ill_flag",   64'(b64.out_illegal), 64'd1);
    check("ill_imm",    b64.out_imm, 64'd0);
    check("ill_type",   64'(b64.out_imm_type), 64'd7);
    check("ill_flag32", 64'(b32.out_illegal), 64'd1);

    // Asynchronous reset mid-stream
    @(posedge clk); #1;
    b64.out_ready = 1'b0;
    send(32'h00C00613);
    send(32'h0DEAD6B7);
    base64 = n_out64;
    #2 reset = 1'b1;
    #1 check_reset_outputs("midrst");
    @(posedge clk); #1;
    reset = 1'b0;
    b64.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("midrst_no_replay", 64'(n_out64 - base64), 64'd0);
    send(32'hFFF00093);
    repeat (3) @(posedge clk);
    #1;
    check("post_rst_count", 64'(n_out64 - base64), 64'd1);
    check("post_rst_drain", 64'(q64.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
